// File: rtl/arb_rr_grant_if.sv
// ---------------------------------------------------------------------------
// arb_rr_grant_if
// Request/grant bundle between a set of agents and the round-robin arbiter.
//
// Parameters
//   NUM_AGENTS  number of requesters (>= 2)
//
// Signals
//   req        agents -> arbiter   per-agent level request
//   ack        arbiter -> agents   per-agent grant, one-hot or zero
//   gnt_valid  arbiter -> agents   high while any ack bit is set
//   gnt_idx    arbiter -> agents   index of the set ack bit, 0 when idle
//
// Modports
//   master  agent side (drives req)
//   slave   arbiter side (drives ack, gnt_valid, gnt_idx)
// ---------------------------------------------------------------------------
interface arb_rr_grant_if #(
    parameter int NUM_AGENTS = 2
) ();
    localparam int IDX_W = $clog2(NUM_AGENTS);

    logic [NUM_AGENTS-1:0] req;
    logic [NUM_AGENTS-1:0] ack;
    logic                  gnt_valid;
    logic [IDX_W-1:0]      gnt_idx;

    modport master (output req, input ack, input gnt_valid, input gnt_idx);
    modport slave  (input req, output ack, output gnt_valid, output gnt_idx);
endinterface

// File: rtl/arb_rr_grant.sv
// ---------------------------------------------------------------------------
// arb_rr_grant
// Round-robin arbiter in front of the shared NPU resource port. Grants one
// agent at a time with a registered one-hot ack, keeps the grant while the
// owner holds req, and (when MAX_HOLD > 0) forces a hand-over after MAX_HOLD
// consecutive cycles if anybody else is waiting.
//
// Parameters
//   NUM_AGENTS  number of requesters (>= 2)
//   MAX_HOLD    max consecutive grant cycles while others wait, 0 = unlimited
//
// Ports
//   clk   clock, everything on posedge
//   rst   synchronous active-high reset
//   bus   arb_rr_grant_if slave modport (req in; ack/gnt_valid/gnt_idx out)
// ---------------------------------------------------------------------------
module arb_rr_grant #(
    parameter int NUM_AGENTS = 2,
    parameter int MAX_HOLD   = 4
) (
    input  logic          clk,
    input  logic          rst,
    arb_rr_grant_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_AGENTS);
    localparam int HC_W  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(MAX_HOLD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_AGENTS - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state, state_n;
    logic [IDX_W-1:0]      last_ptr, last_ptr_n;
    logic [HC_W-1:0]       hold_cnt, hold_cnt_n;
    logic [NUM_AGENTS-1:0] owner_oh;
    logic [NUM_AGENTS-1:0] others;

    // Search mask starting just after ptr and wrapping; ptr itself is
    // visited last, so the previous owner has the lowest priority.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_AGENTS-1:0] mask,
                                                 input logic [IDX_W-1:0]      ptr);
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] cand_idx;
        logic             found;
        int               cand;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_AGENTS; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_AGENTS) cand = cand - NUM_AGENTS;
            cand_idx = IDX_W'(cand);
            if (!found && mask[cand_idx]) begin
                sel   = cand_idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // last_ptr doubles as the owner index while in GRANT, since it is
    // loaded with the granted index on every new grant.
    assign owner_oh = {{(NUM_AGENTS-1){1'b0}}, 1'b1} << last_ptr;
    assign others   = bus.req & ~owner_oh;

    // State register: arbitration state, rotation pointer and hold counter.
    // Reset parks the pointer on the last agent so agent 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_ptr <= LAST_IDX;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            last_ptr <= last_ptr_n;
            hold_cnt <= hold_cnt_n;
        end
    end

    // Next-state logic: keep the owner while it requests and is under its
    // hold cap (or nobody else is waiting); otherwise hand over directly to
    // the next requester so there is no idle cycle between grants.
    always_comb begin
        state_n    = state;
        last_ptr_n = last_ptr;
        hold_cnt_n = hold_cnt;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_n    = GRANT;
                    last_ptr_n = rr_pick(bus.req, last_ptr);
                    hold_cnt_n = HC_W'(1);
                end
            end
            GRANT: begin
                if (bus.req[last_ptr] &&
                    ((MAX_HOLD == 0) || (hold_cnt < HOLD_MAX) || (others == '0))) begin
                    if (hold_cnt < HOLD_MAX) hold_cnt_n = hold_cnt + HC_W'(1);
                end else if (others != '0) begin
                    last_ptr_n = rr_pick(others, last_ptr);
                    hold_cnt_n = HC_W'(1);
                end else begin
                    state_n    = IDLE;
                    hold_cnt_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are pure decodes of registered state, so they change only on
    // the clock edge and never follow req combinationally.
    always_comb begin
        bus.ack       = '0;
        bus.gnt_valid = 1'b0;
        bus.gnt_idx   = '0;
        if (state == GRANT) begin
            bus.ack       = owner_oh;
            bus.gnt_valid = 1'b1;
            bus.gnt_idx   = last_ptr;
        end
    end
endmodule

// File: tb/tb_arb_rr_grant.sv
// ---------------------------------------------------------------------------
// tb_arb_rr_grant
// Bench for arb_rr_grant with three instances: N=2/MAX_HOLD=4,
// N=4/MAX_HOLD=4 and N=4/MAX_HOLD=0. Directed vectors push the expected ack
// into a per-instance queue; a monitor pops and compares after each edge and
// also checks the output invariants every cycle.
// ---------------------------------------------------------------------------
module tb_arb_rr_grant;
    localparam int D2  = 0;
    localparam int D4  = 1;
    localparam int D4U = 2;
    localparam int WAIT_BOUND = (4 - 1) * 4 + 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    arb_rr_grant_if #(.NUM_AGENTS(2)) if2  ();
    arb_rr_grant_if #(.NUM_AGENTS(4)) if4  ();
    arb_rr_grant_if #(.NUM_AGENTS(4)) if4u ();

    arb_rr_grant #(.NUM_AGENTS(2), .MAX_HOLD(4)) dut2  (.clk(clk), .rst(rst), .bus(if2.slave));
    arb_rr_grant #(.NUM_AGENTS(4), .MAX_HOLD(4)) dut4  (.clk(clk), .rst(rst), .bus(if4.slave));
    arb_rr_grant #(.NUM_AGENTS(4), .MAX_HOLD(0)) dut4u (.clk(clk), .rst(rst), .bus(if4u.slave));

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] q2  [$];
    logic [3:0] q4  [$];
    logic [3:0] q4u [$];

    bit         rnd_on = 1'b0;
    int         wait_cnt [4];
    logic [3:0] prev2  = '0;
    logic [3:0] prev4  = '0;
    logic [3:0] prev4u = '0;

    // Drive one cycle of stimulus at the falling edge and record what the
    // selected instance must show after the following rising edge.
    task automatic applyStimulus(input int sel, input logic r,
                                 input logic [3:0] rq, input logic [3:0] ex);
        @(negedge clk);
        rst = r;
        case (sel)
            D2:      begin if2.req  = rq[1:0]; q2.push_back(ex);  end
            D4:      begin if4.req  = rq;      q4.push_back(ex);  end
            default: begin if4u.req = rq;      q4u.push_back(ex); end
        endcase
    endtask

    function automatic logic [1:0] idxOf(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    // Compare one scoreboard entry against the outputs.
    task automatic checkOutput(input string name, input logic [3:0] a,
                               input logic gv, input logic [1:0] gi,
                               input logic [3:0] ex);
        vectors++;
        if (a !== ex || gv !== (|ex) || gi !== idxOf(ex)) begin
            miscompares++;
            $display("[TB] FAIL %s t=%0t: ack=%b gnt_valid=%b gnt_idx=%0d, expected ack=%b gnt_valid=%b gnt_idx=%0d",
                     name, $time, a, gv, gi, ex, |ex, idxOf(ex));
        end
    endtask

    // Per-cycle invariants: one-hot ack, consistent valid/index, and no ack
    // bit rising without its request present before the edge.
    task automatic checkInvariants(input string name, input logic [3:0] a,
                                   input logic gv, input logic [1:0] gi,
                                   input logic [3:0] rq, input logic [3:0] pa);
        vectors++;
        if (!$onehot0(a) || gv !== (|a) || gi !== idxOf(a) || (a & ~pa & ~rq) != 4'b0) begin
            miscompares++;
            $display("[TB] FAIL %s_invariant t=%0t: ack=%b gnt_valid=%b gnt_idx=%0d req=%b prev_ack=%b",
                     name, $time, a, gv, gi, rq, pa);
        end
    endtask

    // Monitor: sample 1 time unit after every rising edge.
    initial begin
        logic [3:0] a2, a4, a4u;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            a2  = {2'b00, if2.ack};
            a4  = if4.ack;
            a4u = if4u.ack;
            checkInvariants("dut2",  a2,  if2.gnt_valid,  {1'b0, if2.gnt_idx}, {2'b00, if2.req}, prev2);
            checkInvariants("dut4",  a4,  if4.gnt_valid,  if4.gnt_idx,  if4.req,  prev4);
            checkInvariants("dut4u", a4u, if4u.gnt_valid, if4u.gnt_idx, if4u.req, prev4u);
            if (q2.size()  > 0) checkOutput("dut2",  a2,  if2.gnt_valid,  {1'b0, if2.gnt_idx}, q2.pop_front());
            if (q4.size()  > 0) checkOutput("dut4",  a4,  if4.gnt_valid,  if4.gnt_idx,  q4.pop_front());
            if (q4u.size() > 0) checkOutput("dut4u", a4u, if4u.gnt_valid, if4u.gnt_idx, q4u.pop_front());
            if (rnd_on) begin
                for (int i = 0; i < 4; i++) begin
                    if (if4.req[i] && !a4[i]) wait_cnt[i]++;
                    else wait_cnt[i] = 0;
                    vectors++;
                    if (wait_cnt[i] > WAIT_BOUND) begin
                        miscompares++;
                        $display("[TB] FAIL wait_bound agent %0d t=%0t: waited %0d cycles, limit %0d",
                                 i, $time, wait_cnt[i], WAIT_BOUND);
                        wait_cnt[i] = 0;
                    end
                end
            end
            prev2  = a2;
            prev4  = a4;
            prev4u = a4u;
        end
    end

    initial begin
        rst      = 1'b1;
        if2.req  = '0;
        if4.req  = '0;
        if4u.req = '0;

        // Single request from reset, then release.
        applyStimulus(D2, 1'b1, 4'b00, 4'b00);
        applyStimulus(D2, 1'b0, 4'b01, 4'b01);
        applyStimulus(D2, 1'b0, 4'b00, 4'b00);
        applyStimulus(D2, 1'b0, 4'b00, 4'b00);

        // Both agents held: 4 cycles each, no bubble at the switch.
        applyStimulus(D2, 1'b1, 4'b11, 4'b00);
        repeat (4) applyStimulus(D2, 1'b0, 4'b11, 4'b01);
        repeat (4) applyStimulus(D2, 1'b0, 4'b11, 4'b10);
        repeat (2) applyStimulus(D2, 1'b0, 4'b11, 4'b01);
        applyStimulus(D2, 1'b0, 4'b00, 4'b00);

        // Reset in the middle of agent 1's grant restores the pointer.
        applyStimulus(D2, 1'b1, 4'b00, 4'b00);
        repeat (4) applyStimulus(D2, 1'b0, 4'b11, 4'b01);
        applyStimulus(D2, 1'b0, 4'b11, 4'b10);
        applyStimulus(D2, 1'b1, 4'b11, 4'b00);
        applyStimulus(D2, 1'b0, 4'b11, 4'b01);
        applyStimulus(D2, 1'b0, 4'b00, 4'b00);

        // Unlimited hold: agent 0 keeps the grant, then releases in turn.
        applyStimulus(D4U, 1'b1, 4'b0000, 4'b0000);
        repeat (12) applyStimulus(D4U, 1'b0, 4'b1111, 4'b0001);
        applyStimulus(D4U, 1'b0, 4'b1110, 4'b0010);
        applyStimulus(D4U, 1'b0, 4'b1100, 4'b0100);
        applyStimulus(D4U, 1'b0, 4'b1000, 4'b1000);
        applyStimulus(D4U, 1'b0, 4'b0000, 4'b0000);

        // Pointer wrap 3 -> 0, then release hands over to agent 2.
        applyStimulus(D4, 1'b1, 4'b0000, 4'b0000);
        applyStimulus(D4, 1'b0, 4'b1000, 4'b1000);
        applyStimulus(D4, 1'b0, 4'b0000, 4'b0000);
        applyStimulus(D4, 1'b0, 4'b0101, 4'b0001);
        applyStimulus(D4, 1'b0, 4'b0100, 4'b0100);
        applyStimulus(D4, 1'b0, 4'b0000, 4'b0000);

        // Four agents all requesting: full rotation with the hold cap.
        applyStimulus(D4, 1'b1, 4'b0000, 4'b0000);
        repeat (4) applyStimulus(D4, 1'b0, 4'b1111, 4'b0001);
        repeat (4) applyStimulus(D4, 1'b0, 4'b1111, 4'b0010);
        repeat (4) applyStimulus(D4, 1'b0, 4'b1111, 4'b0100);
        repeat (4) applyStimulus(D4, 1'b0, 4'b1111, 4'b1000);
        applyStimulus(D4, 1'b0, 4'b1111, 4'b0001);
        applyStimulus(D4, 1'b0, 4'b1110, 4'b0010);
        applyStimulus(D4, 1'b0, 4'b0000, 4'b0000);

        // Random phase on the N=4 capped instance; agents hold req until
        // acked and may drop it only while they own the grant.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        rnd_on = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (if4.req[i] && if4.ack[i]) begin
                    if ($urandom_range(3) == 0) if4.req[i] = 1'b0;
                end else if (!if4.req[i]) begin
                    if ($urandom_range(2) == 0) if4.req[i] = 1'b1;
                end
            end
        end
        @(negedge clk);
        rnd_on  = 1'b0;
        if4.req = '0;

        // Let the monitor drain any outstanding expectations.
        for (int k = 0; k < 4 && (q2.size() + q4.size() + q4u.size()) > 0; k++) @(negedge clk);
        if ((q2.size() + q4.size() + q4u.size()) > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0",
                     q2.size() + q4.size() + q4u.size());
        end
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
